// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_fifo
// Brief   : Unloads bytes from a UART receiver and buffers them in a
//           DEPTH-entry FIFO with a first-word-fall-through valid/ready
//           read port. It stops unloading while full, so the UART itself
//           reports the overrun.
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          reset,
  input  logic          rxclk,
  input  logic [7:0]    rx_data,
  input  logic          rx_empty,
  output logic          uld_rx_data,
  input  logic          flush,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [AW:0]   level,
  output logic          full,
  output logic          stall
);

  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    UNLOAD  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          uld_next;
  logic          push;
  logic          pop;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    mem [DEPTH];

  // Read side and status flags are combinational from pointers and count.
  assign rd_data  = mem[rd_ptr];
  assign rd_valid = (level != '0);
  assign full     = (level == FULL_LVL);
  assign stall    = !rx_empty && full && (state == IDLE);
  // Flush wins over a pop in the same cycle.
  assign pop      = rd_valid && rd_ready && !flush;

  // Unload sequencer state and the registered unload pulse.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      uld_rx_data <= 1'b0;
    end else begin
      state       <= state_next;
      uld_rx_data <= uld_next;
    end
  end

  // Next-state logic: space is only checked in IDLE, so the CAPTURE write
  // always has room (a pop in between can only free space).
  always_comb begin
    state_next = state;
    uld_next   = 1'b0;
    push       = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_empty && !full) begin
          state_next = UNLOAD;
          uld_next   = 1'b1;
        end
      end
      UNLOAD: begin
        state_next = CAPTURE;
      end
      CAPTURE: begin
        push       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (flush) begin
      state_next = IDLE;
      uld_next   = 1'b0;
      push       = 1'b0;
    end
  end

  // Pointer and occupancy tracking; flush clears everything synchronously.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge rxclk) begin
    if (push) begin
      mem[wr_ptr] <= rx_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx_fifo
// Brief   : Directed self-checking bench for uart_rx_fifo with a cycle-level
//           UART receiver model and a consumer that records popped bytes.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  logic       reset;
  logic       rxclk;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       uld_rx_data;
  logic       flush;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [4:0] level;
  logic       full;
  logic       stall;

  int total = 0;
  int bad   = 0;

  // UART model state
  logic [7:0] hold_byte = 8'h00;
  logic [7:0] uq [$];
  logic [7:0] got [$];
  bit         b2b = 1'b0;
  int         gap = 0;
  int         pulses = 0;
  int         max_level = 0;

  uart_rx_fifo #(.DEPTH(16), .AW(4)) dut (
    .reset      (reset),
    .rxclk      (rxclk),
    .rx_data    (rx_data),
    .rx_empty   (rx_empty),
    .uld_rx_data(uld_rx_data),
    .flush      (flush),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .level      (level),
    .full       (full),
    .stall      (stall)
  );

  initial rxclk = 1'b0;
  always #5 rxclk = ~rxclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: record a pop, let the edge happen, then the UART reacts.
  task automatic tick();
    logic u;
    u = uld_rx_data;
    if (rd_valid === 1'b1 && rd_ready && !flush && !reset) got.push_back(rd_data);
    @(posedge rxclk);
    #1;
    if (u && !reset) begin
      pulses++;
      rx_data = hold_byte;
      if (b2b && uq.size() > 0) begin
        hold_byte = uq.pop_front();
        rx_empty  = 1'b0;
      end else begin
        rx_empty = 1'b1;
        gap      = 1;
      end
    end else begin
      if (gap > 0) gap--;
      else if (rx_empty && uq.size() > 0) begin
        hold_byte = uq.pop_front();
        rx_empty  = 1'b0;
      end
    end
    if (int'(level) > max_level) max_level = int'(level);
  endtask

  task automatic present(input logic [7:0] b);
    hold_byte = b;
    rx_empty  = 1'b0;
  endtask

  initial begin
    int p0;
    int errs;
    reset    = 1'b1;
    rx_empty = 1'b1;
    rx_data  = 8'h00;
    flush    = 1'b0;
    rd_ready = 1'b0;
    #12;
    check("rst_level", level, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_full", full, 0);
    check("rst_stall", stall, 0);
    check("rst_uld", uld_rx_data, 0);
    @(posedge rxclk); #1;
    reset = 1'b0;

    // Pop while empty is ignored
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("empty_pop_level", level, 0);

    // Single byte
    present(8'hA5);
    tick();
    check("single_uld_hi", uld_rx_data, 1);
    tick();
    check("single_uld_lo", uld_rx_data, 0);
    check("single_not_yet", rd_valid, 0);
    tick();
    check("single_valid", rd_valid, 1);
    check("single_data", rd_data, 8'hA5);
    check("single_level", level, 1);
    tick(); tick();
    check("single_pulses", pulses, 1);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("single_pop_level", level, 0);
    check("single_pop_valid", rd_valid, 0);
    check("single_got", got.size() == 1 ? got[0] : 8'hxx, 8'hA5);

    // Burst to full
    got.delete();
    for (int i = 0; i < 16; i++) uq.push_back(8'(i));
    for (int i = 0; i < 200 && level != 5'd16; i++) tick();
    check("burst_level", level, 16);
    check("burst_full", full, 1);
    p0 = pulses;
    uq.push_back(8'h10);
    tick(); tick(); tick(); tick();
    check("burst_stall", stall, 1);
    check("burst_no_uld", uld_rx_data, 0);
    check("burst_pulses", pulses - p0, 0);
    check("burst_level_hold", level, 16);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("freed_level", level, 15);
    check("freed_stall", stall, 0);
    check("freed_uld_wait", uld_rx_data, 0);
    tick();
    check("freed_uld", uld_rx_data, 1);
    tick(); tick();
    check("refill_level", level, 16);
    got.delete();
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    rd_ready = 1'b0;
    check("drain_count", got.size(), 16);
    errs = 0;
    foreach (got[i]) if (got[i] !== 8'(i + 1)) errs++;
    check("drain_order", errs, 0);
    check("drain_level", level, 0);

    // Wrap-around with simultaneous push/pop
    got.delete();
    max_level = 0;
    p0 = pulses;
    rd_ready = 1'b1;
    for (int i = 0; i < 40; i++) uq.push_back(8'(8'h80 + i));
    for (int i = 0; i < 500 && got.size() < 40; i++) tick();
    rd_ready = 1'b0;
    tick();
    check("wrap_count", got.size(), 40);
    errs = 0;
    foreach (got[i]) if (got[i] !== 8'(8'h80 + i)) errs++;
    check("wrap_order", errs, 0);
    check("wrap_maxlvl_le1", max_level <= 1, 1);
    check("wrap_pulses", pulses - p0, 40);
    check("wrap_level", level, 0);

    // Back-to-back frames
    got.delete();
    p0 = pulses;
    b2b = 1'b1;
    uq.push_back(8'hC2);
    present(8'hC1);
    for (int i = 0; i < 8; i++) tick();
    b2b = 1'b0;
    check("b2b_pulses", pulses - p0, 2);
    check("b2b_level", level, 2);
    rd_ready = 1'b1;
    tick(); tick();
    rd_ready = 1'b0;
    check("b2b_count", got.size(), 2);
    check("b2b_first", got.size() > 0 ? got[0] : 8'hxx, 8'hC1);
    check("b2b_second", got.size() > 1 ? got[1] : 8'hxx, 8'hC2);

    // Flush mid-CAPTURE
    got.delete();
    uq.push_back(8'h31); uq.push_back(8'h32); uq.push_back(8'h33);
    for (int i = 0; i < 100 && level != 5'd3; i++) tick();
    check("flush_pre_level", level, 3);
    present(8'h34);
    tick();
    check("flush_uld", uld_rx_data, 1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_level", level, 0);
    check("flush_valid", rd_valid, 0);
    tick(); tick(); tick();
    check("flush_no_write", level, 0);
    present(8'h35);
    for (int i = 0; i < 10 && rd_valid !== 1'b1; i++) tick();
    check("flush_next_data", rd_data, 8'h35);
    check("flush_next_level", level, 1);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("flush_next_pop", level, 0);

    // Async reset mid-UNLOAD
    present(8'h51);
    for (int i = 0; i < 10 && level != 5'd1; i++) tick();
    check("arst_pre_level", level, 1);
    present(8'h52);
    tick();
    check("arst_uld_hi", uld_rx_data, 1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_uld_drop", uld_rx_data, 0);
    check("arst_level", level, 0);
    check("arst_valid", rd_valid, 0);
    check("arst_stall", stall, 0);
    tick();
    check("arst_hold_uld", uld_rx_data, 0);
    reset = 1'b0;
    p0 = pulses;
    tick();
    check("arst_resume_uld", uld_rx_data, 1);
    for (int i = 0; i < 10 && rd_valid !== 1'b1; i++) tick();
    check("arst_resume_data", rd_data, 8'h52);
    check("arst_resume_level", level, 1);
    check("arst_resume_pulses", pulses - p0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
